// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter that sequences two requesters through one shared ALU,
// registering operands on issue and results on capture.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 4
`endif
module alu_arb #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ARGS_WIDTH = `ARGS_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0_valid,
    input  logic                  i_req1_valid,
    output logic                  o_req0_ready,
    output logic                  o_req1_ready,
    input  logic [ARGS_WIDTH-1:0] i_req0_type,
    input  logic [ARGS_WIDTH-1:0] i_req1_type,
    input  logic [DATA_WIDTH-1:0] i_req0_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_req0_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_req1_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_req1_rs2_data,
    output logic                  o_rsp0_valid,
    output logic                  o_rsp1_valid,
    input  logic                  i_rsp0_ready,
    input  logic                  i_rsp1_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_res,
    output logic                  o_rsp_zero,
    output logic                  o_rsp_over,
    output logic                  o_rsp_neg,
    output logic [ARGS_WIDTH-1:0] o_alu_type,
    output logic [DATA_WIDTH-1:0] o_alu_rs1_data,
    output logic [DATA_WIDTH-1:0] o_alu_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_alu_res,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_over,
    input  logic                  i_alu_neg,
    output logic                  o_arb_busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e                state_q, state_d;
    logic                  prio_q, prio_d, owner_q, owner_d;
    logic [ARGS_WIDTH-1:0] type_q, type_d;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, res_q, res_d;
    logic                  zero_q, zero_d, over_q, over_d, neg_q, neg_d;
    logic                  grant, accept, rsp_ready;

    // grant selects requester 1 when it alone is valid, prio breaks ties
    assign grant        = (i_req0_valid && i_req1_valid) ? prio_q : i_req1_valid;
    assign accept       = (state_q == IDLE) && (i_req0_valid || i_req1_valid);
    assign rsp_ready    = owner_q ? i_rsp1_ready : i_rsp0_ready;
    assign o_req0_ready = accept && !grant;
    assign o_req1_ready = accept && grant;
    assign o_rsp0_valid = (state_q == RESP) && !owner_q;
    assign o_rsp1_valid = (state_q == RESP) && owner_q;
    assign o_rsp_res    = res_q;
    assign o_rsp_zero   = zero_q;
    assign o_rsp_over   = over_q;
    assign o_rsp_neg    = neg_q;
    assign o_alu_type     = type_q;
    assign o_alu_rs1_data = rs1_q;
    assign o_alu_rs2_data = rs2_q;
    assign o_arb_busy   = state_q != IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            type_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            over_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            type_q  <= type_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            over_q  <= over_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        type_d  = type_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        res_d   = res_q;
        zero_d  = zero_q;
        over_d  = over_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = EXEC;
                owner_d = grant;
                prio_d  = !grant;
                type_d  = grant ? i_req1_type : i_req0_type;
                rs1_d   = grant ? i_req1_rs1_data : i_req0_rs1_data;
                rs2_d   = grant ? i_req1_rs2_data : i_req0_rs2_data;
            end
            EXEC: begin
                state_d = RESP;
                res_d   = i_alu_res;
                zero_d  = i_alu_zero;
                over_d  = i_alu_over;
                neg_d   = i_alu_neg;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: randomized and directed bench for alu_arb with a transaction-level
// arbitration/latency model and a behavioural stand-in for the shared ALU.
module tb_alu_arb;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam logic [AW-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                              OP_OR = 4'd3, OP_XOR = 4'd4, OP_SLT = 4'd5;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0, r0 = 1'b0, r1 = 1'b0;
    logic [AW-1:0] t0 = '0, t1 = '0;
    logic [DW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          rdy0, rdy1, rv0, rv1, rsp_zero, rsp_over, rsp_neg, busy;
    logic [DW-1:0] rsp_res, alu_a, alu_b, alu_res;
    logic [AW-1:0] alu_type;
    logic          alu_zero, alu_over, alu_neg;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [34:0] alu_f(logic [AW-1:0] t, logic [DW-1:0] a, logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic ov;
        r = '0;
        ov = 1'b0;
        case (t)
            OP_ADD: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_SUB: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLT: r = {31'd0, $signed(a) < $signed(b)};
            default: r = '0;
        endcase
        return {r, r == '0, ov, r[31]};
    endfunction

    assign {alu_res, alu_zero, alu_over, alu_neg} = alu_f(alu_type, alu_a, alu_b);

    alu_arb #(.DATA_WIDTH(DW), .ARGS_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(v0), .i_req1_valid(v1),
        .o_req0_ready(rdy0), .o_req1_ready(rdy1),
        .i_req0_type(t0), .i_req1_type(t1),
        .i_req0_rs1_data(a0), .i_req0_rs2_data(b0),
        .i_req1_rs1_data(a1), .i_req1_rs2_data(b1),
        .o_rsp0_valid(rv0), .o_rsp1_valid(rv1),
        .i_rsp0_ready(r0), .i_rsp1_ready(r1),
        .o_rsp_res(rsp_res), .o_rsp_zero(rsp_zero), .o_rsp_over(rsp_over), .o_rsp_neg(rsp_neg),
        .o_alu_type(alu_type), .o_alu_rs1_data(alu_a), .o_alu_rs2_data(alu_b),
        .i_alu_res(alu_res), .i_alu_zero(alu_zero), .i_alu_over(alu_over), .i_alu_neg(alu_neg),
        .o_arb_busy(busy)
    );

    // model: an accepted op answers 2 cycles later and blocks new grants until consumed
    int          cyc, acc_cyc, rsp_cyc, acc;
    bit          inflight, own, pr;
    logic [34:0] exp_rsp, s_pay;
    logic [67:0] exp_ops;
    logic        s_rdy0, s_rdy1, s_rv0, s_busy;
    bit          grant_log[$];
    int          acc_log[$];
    logic [35:0] rsp_log[$];

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; r0 = 1'b0; r1 = 1'b0;
        #1;
        chk("rst_ready", {rdy0, rdy1}, 0);
        chk("rst_rsp_valid", {rv0, rv1}, 0);
        chk("rst_payload", {rsp_res, rsp_zero, rsp_over, rsp_neg}, 0);
        chk("rst_alu", {alu_type, alu_a, alu_b}, 0);
        chk("rst_busy", busy, 0);
        inflight = 0; pr = 0; own = 0; exp_ops = '0; acc = 0;
        grant_log.delete(); acc_log.delete(); rsp_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; acc_cyc = -100; rsp_cyc = -100;
    endtask

    task automatic tick();
        bit idle, rv, g;
        #1;
        idle = !inflight;
        rv = inflight && (cyc >= acc_cyc + 2);
        g = (v0 && v1) ? pr : v1;
        chk("req0_ready", rdy0, idle && v0 && !g);
        chk("req1_ready", rdy1, idle && v1 && g);
        chk("rsp0_valid", rv0, rv && !own);
        chk("rsp1_valid", rv1, rv && own);
        chk("busy", busy, inflight);
        chk("alu_ops", {alu_type, alu_a, alu_b}, exp_ops);
        if (rv) chk("rsp_payload", {rsp_res, rsp_zero, rsp_over, rsp_neg}, exp_rsp);
        s_rdy0 = rdy0; s_rdy1 = rdy1; s_rv0 = rv0; s_busy = busy;
        s_pay = {rsp_res, rsp_zero, rsp_over, rsp_neg};
        acc = 0;
        if (idle && (v0 || v1)) begin
            inflight = 1; acc_cyc = cyc; own = g; pr = !g; acc = int'(g) + 1;
            exp_ops = g ? {t1, a1, b1} : {t0, a0, b0};
            exp_rsp = g ? alu_f(t1, a1, b1) : alu_f(t0, a0, b0);
            grant_log.push_back(g);
            acc_log.push_back(cyc);
        end else if (rv && (own ? r1 : r0)) begin
            inflight = 0; rsp_cyc = cyc;
            rsp_log.push_back({own, s_pay});
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && inflight; k++) tick();
        chk("drain_timeout", inflight, 0);
    endtask

    task automatic issue(bit n, logic [AW-1:0] t, logic [DW-1:0] a, logic [DW-1:0] b);
        if (n) begin v1 = 1; t1 = t; a1 = a; b1 = b; end
        else begin v0 = 1; t0 = t; a0 = a; b0 = b; end
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (acc == int'(n) + 1) break;
        end
        chk("issue_grant", acc, int'(n) + 1);
        if (n) v1 = 0; else v0 = 0;
        drain();
    endtask

    initial begin
        logic [34:0] held;
        int k;
        @(negedge clk);

        do_reset();
        r0 = 1; r1 = 1;
        v0 = 1; t0 = OP_ADD; a0 = 5; b0 = 7;
        tick();
        chk("single_ready0", s_rdy0, 1);
        v0 = 0;
        drain();
        chk("single_latency", rsp_cyc - acc_log[0], 2);
        chk("single_res", rsp_log[0], {1'b0, 32'd12, 3'b000});

        do_reset();
        r0 = 1; r1 = 1;
        v0 = 1; t0 = OP_SUB; a0 = 3; b0 = 3;
        v1 = 1; t1 = OP_OR; a1 = 32'hF0; b1 = 32'h0F;
        for (k = 0; k < 40 && grant_log.size() < 6; k++) tick();
        v0 = 0; v1 = 0;
        drain();
        chk("cont_grants", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("cont_order%0d", i), grant_log[i], i % 2);
        chk("cont_rsp0", rsp_log[0], {1'b0, 32'h0, 3'b100});
        chk("cont_rsp1", rsp_log[1], {1'b1, 32'hFF, 3'b000});
        chk("cont_period", acc_log[1] - acc_log[0], 3);

        do_reset();
        r0 = 0; r1 = 1;
        v0 = 1; t0 = OP_ADD; a0 = 32'h11; b0 = 32'h22;
        v1 = 1; t1 = OP_XOR; a1 = 32'hFF; b1 = 32'h0F;
        tick();
        chk("bp_first", acc, 1);
        v0 = 0;
        for (k = 0; k < 5 && !s_rv0; k++) tick();
        held = s_pay;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_rsp0_valid", s_rv0, 1);
            chk("bp_hold", s_pay, held);
            chk("bp_req1_ready", s_rdy1, 0);
            chk("bp_busy", s_busy, 1);
        end
        r0 = 1;
        tick();
        tick();
        chk("bp_req1_next", acc, 2);
        v1 = 0;
        drain();

        do_reset();
        r0 = 1; r1 = 1;
        issue(0, OP_ADD, 32'h80000000, 32'h80000000);
        chk("flag_add", rsp_log[$], {1'b0, 32'h0, 3'b110});
        issue(0, OP_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF);
        chk("flag_sub", rsp_log[$], {1'b0, 32'h80000000, 3'b011});
        issue(0, OP_SLT, 32'hFFFFFFFF, 32'h1);
        chk("flag_slt", rsp_log[$], {1'b0, 32'h1, 3'b000});
        issue(1, 4'hF, 32'h1234, 32'h5678);
        chk("flag_unknown", rsp_log[$], {1'b1, 32'h0, 3'b100});

        do_reset();
        r0 = 1; r1 = 1;
        v1 = 1; t1 = OP_ADD; a1 = 9; b1 = 9;
        tick();
        chk("mid_grant1", acc, 2);
        v1 = 0;
        do_reset();
        r1 = 1; r0 = 1;
        repeat (6) tick();
        chk("mid_no_rsp", rsp_log.size(), 0);
        v0 = 1; t0 = OP_AND; a0 = 32'hF0F0; b0 = 32'hFF00;
        v1 = 1; t1 = OP_ADD; a1 = 1; b1 = 2;
        tick();
        chk("mid_post_grant0", acc, 1);
        v0 = 0; v1 = 0;
        drain();

        do_reset();
        r0 = 1;
        v0 = 1; t0 = OP_ADD; a0 = 1; b0 = 1;
        k = 0;
        for (int i = 0; i < 30 && k < 3; i++) begin
            tick();
            if (acc == 1) begin
                k++;
                a0 = k + 1; b0 = k + 1;
                if (k == 3) v0 = 0;
            end
        end
        drain();
        chk("tp_period1", acc_log[1] - acc_log[0], 3);
        chk("tp_period2", acc_log[2] - acc_log[1], 3);
        chk("tp_res0", rsp_log[0], {1'b0, 32'd2, 3'b000});
        chk("tp_res1", rsp_log[1], {1'b0, 32'd4, 3'b000});
        chk("tp_res2", rsp_log[2], {1'b0, 32'd6, 3'b000});

        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (acc == 1 || !v0) begin
                v0 = ($urandom_range(0, 1) == 1);
                t0 = AW'($urandom_range(0, 7));
                a0 = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
                b0 = $urandom;
            end else if ($urandom_range(0, 9) == 0) v0 = 0;
            if (acc == 2 || !v1) begin
                v1 = ($urandom_range(0, 1) == 1);
                t1 = AW'($urandom_range(0, 7));
                a1 = $urandom;
                b1 = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            end else if ($urandom_range(0, 9) == 0) v1 = 0;
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            tick();
        end
        v0 = 0; v1 = 0; r0 = 1; r1 = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/alu_arb.md
# alu_arb

Two-requester arbiter and sequencer for the shared combinational `alu`. It accepts operations from two requesters over valid/ready handshakes and grants them round-robin. It drives the ALU from registered operands, captures result and flags, and returns them over a per-requester valid/ready response channel. It sits between the execute-stage issue logic and the single `alu` instance it owns.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): operand/result width.
- `ARGS_WIDTH`, default `` `ARGS_WIDTH ``: ALU opcode width, carries `` `ALU_TYPE_* `` codes.
- `i_clk`  in  1  clock; all state on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req0_valid` / `i_req1_valid`  in  1  request valid, per requester.
- `o_req0_ready` / `o_req1_ready`  out  1  request accepted this cycle.
- `i_req0_type` / `i_req1_type`  in  ARGS_WIDTH  ALU opcode.
- `i_req0_rs1_data`, `i_req0_rs2_data`, `i_req1_rs1_data`, `i_req1_rs2_data`  in  DATA_WIDTH  operands.
- `o_rsp0_valid` / `o_rsp1_valid`  out  1  response valid for that requester.
- `i_rsp0_ready` / `i_rsp1_ready`  in  1  response consumed.
- `o_rsp_res`  out  DATA_WIDTH  shared result payload; qualified by the valids.
- `o_rsp_zero`, `o_rsp_over`, `o_rsp_neg`  out  1 each  shared flag payload.
- `o_alu_type`  out  ARGS_WIDTH  to ALU `i_alu_type`.
- `o_alu_rs1_data`, `o_alu_rs2_data`  out  DATA_WIDTH  to ALU operand inputs.
- `i_alu_res`  in  DATA_WIDTH  from ALU.
- `i_alu_zero`, `i_alu_over`, `i_alu_neg`  in  1 each  from ALU.
- `o_arb_busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP. A 1-bit priority pointer `prio` holds the preferred requester. A 1-bit `owner` holds the requester being served.
- **IDLE:**
  - Grant goes to the valid requester.
  - If both are valid, grant goes to requester `prio`.
  - `o_reqN_ready` = (IDLE && grant==N). It is combinational from the valids.
  - On handshake: latch type and operands into the ALU operand registers, set `owner`=N, set `prio`=~N, go to EXEC.
- **EXEC:**
  - The ALU evaluates the registered operands.
  - At the clock edge, capture `i_alu_res`/zero/over/neg into the response registers, assert `o_rsp<owner>_valid`, go to RESP.
- **RESP:**
  - Hold `o_rsp<owner>_valid` and the payload stable until `i_rsp<owner>_ready`=1.
  - Then deassert valid and go to IDLE.
- The non-owner's `i_rspN_ready` is ignored. The non-owner's `o_rspN_valid` is always 0.
- Requester rules:
  - Keep valid and payload stable until its handshake.
  - Valid must not depend combinationally on ready.
  - Dropping valid before grant is legal; nothing is consumed.
- `o_alu_*` are driven only from the operand registers. Between operations they hold the last issued op.
- Flags are passed through unmodified from the ALU. `o_rsp_over` follows ALU semantics: ADD/SUB signed overflow, 0 for other types.
- Unknown opcodes are forwarded as-is. The ALU default returns res 0 and zero 1.

## Timing
- Reset (async assert, sync-safe release) puts:
  - state in IDLE, `prio`=0, `owner`=0;
  - `o_req*_ready`=0 while no valid, `o_rsp*_valid`=0;
  - `o_rsp_res`=0, `o_rsp_zero`/`o_rsp_over`/`o_rsp_neg`=0;
  - `o_alu_type`=0 and `o_alu_rs*_data`=0;
  - `o_arb_busy`=0.
- Latency, with the handshake at edge E0: EXEC is the cycle after E0, and `o_rspN_valid` rises in the cycle after E1, i.e. 2 cycles after acceptance.
- Throughput is one operation per 3 cycles, reached when the response is consumed in its first valid cycle. A new request can be accepted in the cycle after the response handshake.
- Simultaneous requests in IDLE: exactly one is granted, and the loser's ready stays 0.
- Under continuous contention, grants strictly alternate 0,1,0,1.
- Response backpressure stalls the block indefinitely. No request is accepted while in EXEC or RESP.
- Reset mid-operation (EXEC or RESP):
  - all outputs go immediately to their reset values;
  - the in-flight operation is discarded and no response is ever issued for it;
  - the next grant after reset favours requester 0.

## Test plan
- Single op: req0 `` `ALU_TYPE_ADD `` 5,7.
  - Expect `o_req0_ready`=1 on the handshake cycle and `o_rsp0_valid` 2 cycles later.
  - Expect res=12, zero=0, over=0, neg=0, and `o_rsp1_valid`=0 throughout.
- Contention right after reset: req0 `` `ALU_TYPE_SUB `` 3,3 and req1 `` `ALU_TYPE_OR `` 0xF0,0x0F, both valid.
  - req0 is served first: res=0, zero=1.
  - req1 is served next: res=0xFF.
  - With both held valid for 6 ops, the grant order is 0,1,0,1,0,1.
- Backpressure: hold `i_rsp0_ready`=0 for 4 cycles with req1 valid.
  - `o_rsp0_valid` and the payload stay stable.
  - `o_req1_ready` stays 0 and `o_arb_busy`=1.
  - req1 is granted in the cycle after the rsp0 handshake.
- Flags, DATA_WIDTH=32:
  - ADD 0x80000000,0x80000000 gives res=0, zero=1, over=1.
  - SUB 0x7FFFFFFF,0xFFFFFFFF gives res=0x80000000, over=1, neg=1.
  - `` `ALU_TYPE_SLT `` 0xFFFFFFFF,1 gives res=1, over=0.
- Reset mid-op: drop `i_rst_n` during EXEC of a req1 op.
  - All valids/ready go 0 immediately, and no rsp1 appears after release.
  - Both requesters valid afterwards leads to req0 granted first.
- Throughput: req0 valid continuously and `i_rsp0_ready` tied 1 gives one handshake every 3 cycles and correct results for an ADD sequence 1+1, 2+2, 3+3 (results 2, 4, 6).
